// File: rtl/fn2_pkg.sv
// Shared types and constants for the fn2 two-requester arbiter.
package fn2_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    localparam int NUM_REQ   = 2;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/fn2_unit.sv
// Combinational 2x2-bit function: a = {p,q}, b = {r,s}, c = {c1,c0}.
module fn2_unit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [1:0] c_o
);

    logic p, q, r, s;

    assign p = a_i[1];
    assign q = a_i[0];
    assign r = b_i[1];
    assign s = b_i[0];

    assign c_o[1] = (~p & r & s) | (~p & q & r) | (p & ~r);
    assign c_o[0] = (p | q | s) & (q | r) & (~p | r);

endmodule

// File: rtl/fn2_arbiter.sv
// Two-requester round-robin arbiter feeding fn2_unit into a one-entry output register.
// Optional per-requester grant counters are built when FN2_ARBITER_STATS_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no result held, any granted pair is accepted
// ST_FULL  | result held on out_c/out_id, out_valid high
module fn2_arbiter
    import fn2_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    input  logic [1:0]       req_a_0,
    input  logic [1:0]       req_a_1,
    input  logic [1:0]       req_b_0,
    input  logic [1:0]       req_b_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    output logic             out_valid,
    output logic [1:0]       out_c,
    output logic             out_id,
`ifdef FN2_ARBITER_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt_0,
    output logic [CNT_W-1:0] grant_cnt_1,
`endif
    input  logic             out_ready
);

    out_state_e         state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [1:0]         out_c_q, out_c_d;
    logic               out_id_q, out_id_d;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic               can_accept;
    logic               in_xfer;
    logic [1:0]         sel_a, sel_b, fn_c;

    // With both valid, the requester that did not win last time is granted.
    assign grant[0] = req_valid_0 & (~req_valid_1 | last_grant_q);
    assign grant[1] = req_valid_1 & (~req_valid_0 | ~last_grant_q);

    assign can_accept = (state_q == ST_EMPTY) | out_ready;
    // Readies are forced low while reset is held, even though the state already reads EMPTY.
    assign ready      = grant & {NUM_REQ{can_accept & ~rst}};
    assign in_xfer    = |ready;

    assign sel_a = grant[1] ? req_a_1 : req_a_0;
    assign sel_b = grant[1] ? req_b_1 : req_b_0;

    fn2_unit u_fn2_unit (
        .a_i (sel_a),
        .b_i (sel_b),
        .c_o (fn_c)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_c_d      = out_c_q;
        out_id_d     = out_id_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (in_xfer)        state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (in_xfer) begin
            out_c_d      = fn_c;
            out_id_d     = ready[1];
            last_grant_d = ready[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= 1'b1;
            out_c_q      <= 2'b00;
            out_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_c_q      <= out_c_d;
            out_id_q     <= out_id_d;
        end
    end

    assign req_ready_0 = ready[0];
    assign req_ready_1 = ready[1];
    assign out_valid   = (state_q == ST_FULL);
    assign out_c       = out_c_q;
    assign out_id      = out_id_q;

`ifdef FN2_ARBITER_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic [CNT_W-1:0] cnt_d [NUM_REQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr)
                cnt_d[i] = '0;
            else if (ready[i] && (cnt_q[i] != {CNT_W{1'b1}}))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign grant_cnt_0 = cnt_q[0];
    assign grant_cnt_1 = cnt_q[1];
`endif

endmodule

// File: doc/fn2_arbiter.md
FN2_ARBITER -- requirements
Module: fn2_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the per-requester grant counters.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req_valid_0 / req_valid_1  input  1 each  the requester has an operand pair.
REQ-005 Port: req_a_0 / req_a_1  input  2 each  operand a, with p=a[1] and q=a[0].
REQ-006 Port: req_b_0 / req_b_1  input  2 each  operand b, with r=b[1] and s=b[0].
REQ-007 Port: req_ready_0 / req_ready_1  output  1 each  the operand pair is accepted this cycle.
REQ-008 Port: out_valid  output  1  a result is held.
REQ-009 Port: out_c  output  2  the result.
REQ-010 Port: out_id  output  1  index of the requester that produced the result.
REQ-011 Port: out_ready  input  1  the consumer accepts the result.

Function
REQ-012 The result SHALL be computed as c[1] = p'rs + p'qr + pr' and c[0] = (p+q+s)(q+r)(p'+r).
REQ-013 A transfer on requester i SHALL occur when req_valid_i and req_ready_i are both high.
REQ-014 A transfer on the output SHALL occur when out_valid and out_ready are both high.
REQ-015 can_accept SHALL be high when the output state is EMPTY, or when it is FULL and out_ready is high.
REQ-016 Grant rule:
- with one requester valid, that requester is granted;
- with both valid, the requester other than last_grant is granted.
REQ-017 req_ready_i SHALL equal grant_i AND can_accept.
- At most one req_ready is high in any cycle.
- req_ready SHALL NOT depend on the other requester's ready.
REQ-018 last_grant SHALL update only on an accepted requester transfer.
REQ-019 Output state machine, states EMPTY and FULL:
- EMPTY to FULL on a requester transfer;
- FULL to EMPTY on an output transfer with no requester transfer;
- FULL to FULL with the register reloaded when both transfers occur in the same cycle.
REQ-020 Latency SHALL be 1 cycle: out_c and out_id are registered on the accept edge, and out_valid is high the next cycle.
REQ-021 While FULL and out_ready is low:
- out_c and out_id SHALL hold stable;
- both req_ready outputs SHALL be low.
REQ-022 A continuously valid pair of requesters with out_ready held high SHALL see alternating grants with one result per cycle.

Reset
REQ-023 While rst is high the block SHALL be held in its reset state:
- output state EMPTY;
- out_valid=0, out_c=2'b00, out_id=0;
- last_grant=1, so requester 0 wins the first contention;
- grant counters at 0.
REQ-024 Reset asserted mid-operation SHALL discard any held result without an output transfer.
REQ-025 No ready SHALL be asserted while rst is high.

Configuration
REQ-026 With FN2_ARBITER_STATS_EN defined, the block SHALL have these ports:
- stats_clr  input  1;
- grant_cnt_0 / grant_cnt_1  output  CNT_W each.
REQ-027 With FN2_ARBITER_STATS_EN defined, each grant counter SHALL:
- increment on each requester transfer on its port;
- saturate at 2^CNT_W-1.
REQ-028 With FN2_ARBITER_STATS_EN defined, stats_clr SHALL clear both counters synchronously and take priority over an increment in the same cycle.
REQ-029 Without FN2_ARBITER_STATS_EN, neither the stats ports nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-030 The shared package fn2_pkg SHALL hold:
- the output state enum (EMPTY, FULL);
- the requester count constant NUM_REQ=2;
- the default grant counter width.
REQ-031 The function of REQ-012 SHALL be a purely combinational sub-module, fn2_unit, instantiated once and fed by the granted operand mux.

Verification
REQ-032 Only requester 0 valid with a=00, b=11 -> req_ready_0=1; next cycle out_valid=1, out_c=11, out_id=0.
REQ-033 Both requesters valid after reset, with r0 a=10 b=00 and r1 a=01 b=10, and out_ready held high -> first result out_c=10 id 0, next result out_c=11 id 1.
REQ-034 Result held with out_ready=0 for 3 cycles and r1 valid with a=11 b=01 -> both readies low and out_c stable; after out_ready rises, the next result is out_c=10 id 1.
REQ-035 rst pulsed while FULL -> out_valid=0 and out_c=00 immediately; then a=00 b=00 from r1 -> out_c=00 id 1.
REQ-036 With FN2_ARBITER_STATS_EN and CNT_W=2, five transfers on r0 -> grant_cnt_0=3 (saturated); stats_clr plus a transfer in the same cycle -> grant_cnt_0=0.
